// File: rtl/gemm_sched_pkg.sv
// Shared types for the GeMM loop scheduler: FSM states, write-back tag and job descriptor.
package gemm_sched_pkg;

  // Field widths of the packed types below; the scheduler's SizeAddrWidth/AddrWidth
  // parameters are expected to match these.
  localparam int unsigned DefSizeAddrWidth = 8;
  localparam int unsigned DefAddrWidth     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sched_state_e;

  // One entry of the write-back tag pipe; travels alongside the MAC latency.
  typedef struct packed {
    logic                        valid;
    logic                        last;
    logic [DefSizeAddrWidth-1:0] m;
    logic [DefSizeAddrWidth-1:0] n;
  } wb_tag_t;

  typedef struct packed {
    logic [DefSizeAddrWidth-1:0] m_size;
    logic [DefSizeAddrWidth-1:0] k_size;
    logic [DefSizeAddrWidth-1:0] n_size;
    logic [DefAddrWidth-1:0]     a_base;
    logic [DefAddrWidth-1:0]     b_base;
    logic [DefAddrWidth-1:0]     c_base;
  } gemm_job_t;

  // A job with any empty dimension is rejected without touching the SRAMs.
  function automatic logic job_has_zero(gemm_job_t job);
    return (job.m_size == '0) || (job.k_size == '0) || (job.n_size == '0);
  endfunction

endpackage

// File: rtl/gemm_loop_scheduler_if.sv
// Config handshake, stall input and SRAM/MAC control bundle of the GeMM loop scheduler.
interface gemm_loop_scheduler_if #(
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned AddrWidth     = 16
);

  logic                     cfg_valid_i;
  logic                     cfg_ready_o;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] K_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic [AddrWidth-1:0]     a_base_i;
  logic [AddrWidth-1:0]     b_base_i;
  logic [AddrWidth-1:0]     c_base_i;
  logic                     stall_i;
  logic [AddrWidth-1:0]     sram_a_addr_o;
  logic [AddrWidth-1:0]     sram_b_addr_o;
  logic [AddrWidth-1:0]     sram_c_addr_o;
  logic                     operand_valid_o;
  logic                     init_save_o;
  logic                     acc_clr_o;
  logic                     sram_c_we_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;

  // Host / datapath side.
  modport master (
    output cfg_valid_i, M_size_i, K_size_i, N_size_i, a_base_i, b_base_i, c_base_i, stall_i,
    input  cfg_ready_o, sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, operand_valid_o,
    input  init_save_o, acc_clr_o, sram_c_we_o, busy_o, done_o, err_o
  );

  // Scheduler side.
  modport slave (
    input  cfg_valid_i, M_size_i, K_size_i, N_size_i, a_base_i, b_base_i, c_base_i, stall_i,
    output cfg_ready_o, sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, operand_valid_o,
    output init_save_o, acc_clr_o, sram_c_we_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/gemm_wb_tag_pipe.sv
// MacLatency-deep shift register of write-back tags; flags the C write when a last-K tag exits.
module gemm_wb_tag_pipe
  import gemm_sched_pkg::*;
#(
  parameter int unsigned MacLatency = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  wb_tag_t                     tag_i,
  output logic                        we_o,
  output logic [DefSizeAddrWidth-1:0] m_o,
  output logic [DefSizeAddrWidth-1:0] n_o
);

  wb_tag_t stage_q [MacLatency];

  // Shift every cycle, stalls included; a stalled cycle pushes an invalid tag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MacLatency; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < MacLatency; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Only the last K block of an output tile produces a C write.
  always_comb begin
    we_o = stage_q[MacLatency-1].valid & stage_q[MacLatency-1].last;
    m_o  = stage_q[MacLatency-1].m;
    n_o  = stage_q[MacLatency-1].n;
  end

endmodule

// File: rtl/gemm_loop_scheduler.sv
// Walks the M->N->K block loop nest of one GeMM job and drives the MAC array / SRAM controls.
module gemm_loop_scheduler
  import gemm_sched_pkg::*;
#(
  parameter int unsigned SizeAddrWidth = DefSizeAddrWidth,
  parameter int unsigned AddrWidth     = DefAddrWidth,
  parameter int unsigned MacLatency    = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  gemm_loop_scheduler_if.slave bus
);

  localparam int unsigned DrainWidth = (MacLatency > 1) ? $clog2(MacLatency) : 1;

  sched_state_e state_q, state_d;

  gemm_job_t                cfg_job;
  gemm_job_t                job_q;
  logic                     err_q;
  logic [SizeAddrWidth-1:0] m_q, n_q, k_q;
  logic [DrainWidth-1:0]    drain_q;

  logic accept;
  logic cfg_zero;
  logic issue;
  logic k_last, n_last, m_last;
  logic last_issue;
  logic drain_last;

  logic [AddrWidth-1:0] a_addr, b_addr, c_addr;

  wb_tag_t                     tag_in;
  logic                        wb_we;
  logic [DefSizeAddrWidth-1:0] wb_m, wb_n;

  // Decode of the incoming descriptor, loop-end conditions and issue strobe.
  always_comb begin
    cfg_job.m_size = bus.M_size_i;
    cfg_job.k_size = bus.K_size_i;
    cfg_job.n_size = bus.N_size_i;
    cfg_job.a_base = bus.a_base_i;
    cfg_job.b_base = bus.b_base_i;
    cfg_job.c_base = bus.c_base_i;
    cfg_zero       = job_has_zero(cfg_job);
    accept         = (state_q == StIdle) && bus.cfg_valid_i;
    // A stall always wins over an issue, including the final one.
    issue          = (state_q == StRun) && !bus.stall_i;
    k_last         = (k_q == job_q.k_size - SizeAddrWidth'(1));
    n_last         = (n_q == job_q.n_size - SizeAddrWidth'(1));
    m_last         = (m_q == job_q.m_size - SizeAddrWidth'(1));
    last_issue     = issue && k_last && n_last && m_last;
    drain_last     = (drain_q == DrainWidth'(MacLatency - 1));
  end

  // Block addresses, computed modulo 2^AddrWidth from registered counters and latched bases.
  always_comb begin
    a_addr = job_q.a_base + AddrWidth'(m_q) * AddrWidth'(job_q.k_size) + AddrWidth'(k_q);
    b_addr = job_q.b_base + AddrWidth'(n_q) * AddrWidth'(job_q.k_size) + AddrWidth'(k_q);
    c_addr = job_q.c_base + AddrWidth'(wb_m) * AddrWidth'(job_q.n_size) + AddrWidth'(wb_n);
  end

  // Tag for the current cycle; a non-issuing cycle pushes a bubble.
  always_comb begin
    tag_in.valid = issue;
    tag_in.last  = k_last;
    tag_in.m     = m_q;
    tag_in.n     = n_q;
  end

  gemm_wb_tag_pipe #(
    .MacLatency(MacLatency)
  ) u_wb_tag_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tag_i (tag_in),
    .we_o  (wb_we),
    .m_o   (wb_m),
    .n_o   (wb_n)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cfg_valid_i) begin
          state_d = cfg_zero ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The final C write lands in the last drain cycle.
        if (drain_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Job latch, loop counters (k innermost, then n, then m) and drain cycle counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      job_q   <= '0;
      err_q   <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      if (accept) begin
        job_q <= cfg_job;
        err_q <= cfg_zero;
        m_q   <= '0;
        n_q   <= '0;
        k_q   <= '0;
      end else if (issue) begin
        k_q <= k_last ? '0 : k_q + SizeAddrWidth'(1);
        if (k_last) begin
          n_q <= n_last ? '0 : n_q + SizeAddrWidth'(1);
          if (n_last) begin
            m_q <= m_last ? '0 : m_q + SizeAddrWidth'(1);
          end
        end
      end
      drain_q <= (state_q == StDrain) ? drain_q + DrainWidth'(1) : '0;
    end
  end

  // FSM outputs and C write-back port.
  always_comb begin
    bus.cfg_ready_o     = 1'b0;
    bus.acc_clr_o       = 1'b0;
    bus.busy_o          = 1'b0;
    bus.done_o          = 1'b0;
    bus.err_o           = 1'b0;
    bus.operand_valid_o = 1'b0;
    bus.init_save_o     = 1'b0;
    bus.sram_a_addr_o   = '0;
    bus.sram_b_addr_o   = '0;
    bus.sram_c_we_o     = wb_we;
    bus.sram_c_addr_o   = wb_we ? c_addr : '0;
    unique case (state_q)
      StIdle: begin
        bus.cfg_ready_o = 1'b1;
        bus.acc_clr_o   = 1'b1;
      end
      StRun: begin
        bus.busy_o          = 1'b1;
        bus.operand_valid_o = issue;
        bus.init_save_o     = issue && (k_q == '0);
        bus.sram_a_addr_o   = a_addr;
        bus.sram_b_addr_o   = b_addr;
      end
      StDrain: begin
        bus.busy_o        = 1'b1;
        bus.sram_a_addr_o = a_addr;
        bus.sram_b_addr_o = b_addr;
      end
      StDone: begin
        bus.done_o = 1'b1;
        bus.err_o  = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_gemm_loop_scheduler.sv
// Testbench for gemm_loop_scheduler: directed test-plan jobs plus randomized back-to-back jobs
// compared cycle by cycle against a trace model built from the loop-nest rules.
module tb_gemm_loop_scheduler;

  localparam int unsigned SW     = 8;
  localparam int unsigned AW     = 16;
  localparam int          MaxCyc = 512;

  typedef struct {
    int          m;
    int          k;
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } job_t;

  // Control flags of one cycle, followed by the C address.
  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        acc_clr;
    logic        ov;
    logic        init;
    logic        we;
    logic [15:0] caddr;
  } ctl_t;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  gemm_loop_scheduler_if #(.SizeAddrWidth(SW), .AddrWidth(AW)) bus1 ();
  gemm_loop_scheduler_if #(.SizeAddrWidth(SW), .AddrWidth(AW)) bus3 ();

  gemm_loop_scheduler #(
    .SizeAddrWidth(SW),
    .AddrWidth    (AW),
    .MacLatency   (1)
  ) u_dut1 (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus1)
  );

  gemm_loop_scheduler #(
    .SizeAddrWidth(SW),
    .AddrWidth    (AW),
    .MacLatency   (3)
  ) u_dut3 (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus3)
  );

  int vectors     = 0;
  int miscompares = 0;

  bit          stall_arr [MaxCyc];
  ctl_t        exp_ctl   [MaxCyc];
  logic [15:0] exp_a     [MaxCyc];
  logic [15:0] exp_b     [MaxCyc];
  bit          exp_chk   [MaxCyc];
  ctl_t        obs_ctl   [MaxCyc];
  logic [15:0] obs_a     [MaxCyc];
  logic [15:0] obs_b     [MaxCyc];
  int          len;

  localparam ctl_t IdleCtl = '{ready: 1'b1, acc_clr: 1'b1, default: '0};

  function automatic job_t mk_job(int m, int k, int n, logic [15:0] a, logic [15:0] b,
                                  logic [15:0] c);
    job_t j;
    j.m = m; j.k = k; j.n = n; j.a = a; j.b = b; j.c = c;
    return j;
  endfunction

  function automatic job_t rand_job(bit allow_zero);
    job_t j;
    j.m = $urandom_range(4, 1);
    j.k = $urandom_range(4, 1);
    j.n = $urandom_range(4, 1);
    if (allow_zero && ($urandom_range(9) == 0)) begin
      case ($urandom_range(2))
        0: j.m = 0;
        1: j.k = 0;
        default: j.n = 0;
      endcase
    end
    j.a = 16'($urandom);
    j.b = 16'($urandom);
    j.c = 16'($urandom);
    return j;
  endfunction

  task automatic drive(input int sel, input bit valid, input job_t j, input bit stall);
    bus1.cfg_valid_i = 1'b0;
    bus1.stall_i     = 1'b0;
    bus3.cfg_valid_i = 1'b0;
    bus3.stall_i     = 1'b0;
    if (sel == 1) begin
      bus1.cfg_valid_i = valid;
      bus1.stall_i     = stall;
      bus1.M_size_i    = SW'(j.m);
      bus1.K_size_i    = SW'(j.k);
      bus1.N_size_i    = SW'(j.n);
      bus1.a_base_i    = j.a;
      bus1.b_base_i    = j.b;
      bus1.c_base_i    = j.c;
    end else begin
      bus3.cfg_valid_i = valid;
      bus3.stall_i     = stall;
      bus3.M_size_i    = SW'(j.m);
      bus3.K_size_i    = SW'(j.k);
      bus3.N_size_i    = SW'(j.n);
      bus3.a_base_i    = j.a;
      bus3.b_base_i    = j.b;
      bus3.c_base_i    = j.c;
    end
  endtask

  task automatic sample(input int sel, input int c);
    if (sel == 1) begin
      obs_ctl[c] = {bus1.cfg_ready_o, bus1.busy_o, bus1.done_o, bus1.err_o, bus1.acc_clr_o,
                    bus1.operand_valid_o, bus1.init_save_o, bus1.sram_c_we_o,
                    bus1.sram_c_addr_o};
      obs_a[c]   = bus1.sram_a_addr_o;
      obs_b[c]   = bus1.sram_b_addr_o;
    end else begin
      obs_ctl[c] = {bus3.cfg_ready_o, bus3.busy_o, bus3.done_o, bus3.err_o, bus3.acc_clr_o,
                    bus3.operand_valid_o, bus3.init_save_o, bus3.sram_c_we_o,
                    bus3.sram_c_addr_o};
      obs_a[c]   = bus3.sram_a_addr_o;
      obs_b[c]   = bus3.sram_b_addr_o;
    end
  endtask

  task automatic clear_stalls();
    for (int c = 0; c < MaxCyc; c++) stall_arr[c] = 1'b0;
  endtask

  task automatic rand_stalls(input int pct);
    for (int c = 0; c < MaxCyc; c++) stall_arr[c] = ($urandom_range(99) < pct);
  endtask

  // Expected trace: cycle 0 accepts, then the (m,n,k) tuples are issued in loop order on
  // every non-stalled cycle; a last-K issue writes C exactly L cycles later, the job is
  // busy until L cycles after its final issue, and done follows in the next cycle.
  task automatic build_model(input int lat, input job_t j);
    int total, idx, last_c, mm, nn, kk;
    for (int c = 0; c < MaxCyc; c++) begin
      exp_ctl[c] = '0;
      exp_a[c]   = '0;
      exp_b[c]   = '0;
      exp_chk[c] = 1'b1;
    end
    exp_ctl[0] = IdleCtl;
    if (j.m == 0 || j.k == 0 || j.n == 0) begin
      exp_ctl[1].done = 1'b1;
      exp_ctl[1].err  = 1'b1;
      len = 2;
      return;
    end
    total  = j.m * j.n * j.k;
    idx    = 0;
    last_c = MaxCyc;
    len    = MaxCyc;
    for (int c = 1; c < MaxCyc; c++) begin
      if (idx < total) begin
        mm = idx / (j.n * j.k);
        nn = (idx / j.k) % j.n;
        kk = idx % j.k;
        exp_ctl[c].busy = 1'b1;
        exp_a[c] = 16'(int'(j.a) + mm * j.k + kk);
        exp_b[c] = 16'(int'(j.b) + nn * j.k + kk);
        if (!stall_arr[c]) begin
          exp_ctl[c].ov   = 1'b1;
          exp_ctl[c].init = (kk == 0);
          if (kk == j.k - 1 && c + lat < MaxCyc) begin
            exp_ctl[c+lat].we    = 1'b1;
            exp_ctl[c+lat].caddr = 16'(int'(j.c) + mm * j.n + nn);
          end
          idx++;
          if (idx == total) last_c = c;
        end
      end else if (c <= last_c + lat) begin
        exp_ctl[c].busy = 1'b1;
        exp_chk[c]      = 1'b0;
      end else begin
        exp_ctl[c].done = 1'b1;
        len = c + 1;
        break;
      end
    end
  endtask

  // Drives one job (cycle 0 = accept) for n_cyc cycles and records the outputs.
  task automatic run_job(input int sel, input job_t j, input bit noise, input int n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) drive(sel, 1'b1, j, stall_arr[c]);
      else if (noise) drive(sel, 1'($urandom_range(1)), rand_job(1'b1), stall_arr[c]);
      else drive(sel, 1'b0, j, stall_arr[c]);
      @(negedge clk);
      sample(sel, c);
    end
  endtask

  task automatic test_reset();
    job_t z = mk_job(0, 0, 0, 16'h0, 16'h0, 16'h0);
    rst_ni = 1'b0;
    drive(1, 1'b0, z, 1'b0);
    drive(3, 1'b0, z, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 1; s <= 3; s += 2) begin
      sample(s, 0);
      vectors++;
      if (obs_ctl[0] !== IdleCtl || obs_a[0] !== 16'h0 || obs_b[0] !== 16'h0) begin
        miscompares++;
        $display("FAIL reset dut%0d: got ctl=%h a=%h b=%h, want ctl=%h a=0000 b=0000",
                 s, obs_ctl[0], obs_a[0], obs_b[0], IdleCtl);
      end
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    job_t j = mk_job(2, 3, 2, 16'h0000, 16'h0100, 16'h0200);
    int n_ov = 0;
    clear_stalls();
    build_model(1, j);
    run_job(1, j, 1'b0, len);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (obs_ctl[c] !== exp_ctl[c] ||
          (exp_chk[c] && (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]))) begin
        miscompares++;
        $display("FAIL basic cycle %0d: got ctl=%h a=%h b=%h, want ctl=%h a=%h b=%h",
                 c, obs_ctl[c], obs_a[c], obs_b[c], exp_ctl[c], exp_a[c], exp_b[c]);
      end
      n_ov += int'(obs_ctl[c].ov);
    end
    vectors++;
    if (n_ov != 12 || len != 15 || obs_ctl[14].done !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_counts: got issues=%0d done14=%b, want issues=12 done14=1",
               n_ov, obs_ctl[14].done);
    end
    vectors++;
    if (obs_ctl[13].we !== 1'b1 || obs_ctl[13].caddr !== 16'h0203 ||
        obs_ctl[4].caddr !== 16'h0200) begin
      miscompares++;
      $display("FAIL basic_writes: got c13=%b/%h c4=%h, want 1/0203 0200",
               obs_ctl[13].we, obs_ctl[13].caddr, obs_ctl[4].caddr);
    end
  endtask

  task automatic test_stall();
    job_t j = mk_job(2, 3, 2, 16'h0000, 16'h0100, 16'h0200);
    clear_stalls();
    stall_arr[3] = 1'b1;
    stall_arr[4] = 1'b1;
    build_model(1, j);
    run_job(1, j, 1'b0, len);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (obs_ctl[c] !== exp_ctl[c] ||
          (exp_chk[c] && (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]))) begin
        miscompares++;
        $display("FAIL stall cycle %0d: got ctl=%h a=%h b=%h, want ctl=%h a=%h b=%h",
                 c, obs_ctl[c], obs_a[c], obs_b[c], exp_ctl[c], exp_a[c], exp_b[c]);
      end
    end
    vectors++;
    if (obs_a[3] !== 16'h0002 || obs_a[4] !== 16'h0002 || obs_ctl[6].caddr !== 16'h0200 ||
        obs_ctl[15].we !== 1'b1 || obs_ctl[16].done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_points: got a3=%h a4=%h c6=%h we15=%b done16=%b, want 0002 0002 0200 1 1",
               obs_a[3], obs_a[4], obs_ctl[6].caddr, obs_ctl[15].we, obs_ctl[16].done);
    end
  endtask

  task automatic test_zero_size();
    job_t j = mk_job(2, 0, 3, 16'h1234, 16'h5678, 16'h9abc);
    clear_stalls();
    build_model(1, j);
    run_job(1, j, 1'b0, len + 1);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (obs_ctl[c] !== exp_ctl[c] ||
          (exp_chk[c] && (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]))) begin
        miscompares++;
        $display("FAIL zero cycle %0d: got ctl=%h a=%h b=%h, want ctl=%h a=%h b=%h",
                 c, obs_ctl[c], obs_a[c], obs_b[c], exp_ctl[c], exp_a[c], exp_b[c]);
      end
    end
    vectors++;
    if (obs_ctl[1].err !== 1'b1 || obs_ctl[1].done !== 1'b1 || obs_ctl[2].ov !== 1'b0 ||
        obs_ctl[2].we !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_pulse: got err=%b done=%b ov2=%b we2=%b, want 1 1 0 0",
               obs_ctl[1].err, obs_ctl[1].done, obs_ctl[2].ov, obs_ctl[2].we);
    end
  endtask

  task automatic test_latency3();
    job_t j = mk_job(1, 1, 1, 16'h0040, 16'h0080, 16'h0c00);
    clear_stalls();
    build_model(3, j);
    run_job(3, j, 1'b0, len);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (obs_ctl[c] !== exp_ctl[c] ||
          (exp_chk[c] && (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]))) begin
        miscompares++;
        $display("FAIL lat3 cycle %0d: got ctl=%h a=%h b=%h, want ctl=%h a=%h b=%h",
                 c, obs_ctl[c], obs_a[c], obs_b[c], exp_ctl[c], exp_a[c], exp_b[c]);
      end
    end
    vectors++;
    if (obs_ctl[1].init !== 1'b1 || obs_ctl[4].we !== 1'b1 || obs_ctl[4].caddr !== 16'h0c00 ||
        obs_ctl[5].done !== 1'b1) begin
      miscompares++;
      $display("FAIL lat3_points: got init1=%b we4=%b c4=%h done5=%b, want 1 1 0c00 1",
               obs_ctl[1].init, obs_ctl[4].we, obs_ctl[4].caddr, obs_ctl[5].done);
    end
  endtask

  task automatic test_addr_wrap();
    job_t j = mk_job(1, 2, 1, 16'hffff, 16'hfffe, 16'hffff);
    clear_stalls();
    build_model(1, j);
    run_job(1, j, 1'b0, len);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (obs_ctl[c] !== exp_ctl[c] ||
          (exp_chk[c] && (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]))) begin
        miscompares++;
        $display("FAIL wrap cycle %0d: got ctl=%h a=%h b=%h, want ctl=%h a=%h b=%h",
                 c, obs_ctl[c], obs_a[c], obs_b[c], exp_ctl[c], exp_a[c], exp_b[c]);
      end
    end
    vectors++;
    if (obs_a[1] !== 16'hffff || obs_a[2] !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_a: got %h,%h, want ffff,0000", obs_a[1], obs_a[2]);
    end
  endtask

  task automatic test_mid_reset();
    job_t j  = mk_job(2, 3, 2, 16'h0000, 16'h0100, 16'h0200);
    job_t j2 = mk_job(1, 2, 2, 16'h0010, 16'h0020, 16'h0030);
    clear_stalls();
    run_job(1, j, 1'b0, 6);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    drive(1, 1'b0, j, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    sample(1, 0);
    vectors++;
    if (obs_ctl[0] !== IdleCtl || obs_a[0] !== 16'h0 || obs_b[0] !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got ctl=%h a=%h b=%h, want ctl=%h a=0000 b=0000",
               obs_ctl[0], obs_a[0], obs_b[0], IdleCtl);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      sample(1, 0);
      vectors++;
      if (obs_ctl[0] !== IdleCtl) begin
        miscompares++;
        $display("FAIL mid_reset_quiet cycle %0d: got ctl=%h, want ctl=%h",
                 c, obs_ctl[0], IdleCtl);
      end
    end
    build_model(1, j2);
    run_job(1, j2, 1'b0, len);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (obs_ctl[c] !== exp_ctl[c] ||
          (exp_chk[c] && (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]))) begin
        miscompares++;
        $display("FAIL after_reset cycle %0d: got ctl=%h a=%h b=%h, want ctl=%h a=%h b=%h",
                 c, obs_ctl[c], obs_a[c], obs_b[c], exp_ctl[c], exp_a[c], exp_b[c]);
      end
    end
  endtask

  // Random jobs on either DUT, back to back, with random stalls and junk descriptors
  // offered while a job is in flight.
  task automatic test_back_to_back();
    for (int t = 0; t < 40; t++) begin
      int   sel = ($urandom_range(1) == 0) ? 1 : 3;
      job_t j   = rand_job(1'b1);
      rand_stalls(30);
      build_model((sel == 1) ? 1 : 3, j);
      run_job(sel, j, 1'b1, len);
      for (int c = 0; c < len; c++) begin
        vectors++;
        if (obs_ctl[c] !== exp_ctl[c] ||
            (exp_chk[c] && (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]))) begin
          miscompares++;
          $display("FAIL random job %0d dut%0d cycle %0d: got ctl=%h a=%h b=%h, want ctl=%h a=%h b=%h",
                   t, sel, c, obs_ctl[c], obs_a[c], obs_b[c], exp_ctl[c], exp_a[c], exp_b[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_latency3();
    test_addr_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gemm_loop_scheduler.md
Name: gemm_loop_scheduler

Overview:
- Sequences the output-stationary MAC array and its A/B/C SRAMs for one GeMM job at a time.
- Accepts a job descriptor (block counts M/K/N plus SRAM base addresses) over a valid/ready handshake.
- Walks the M→N→K block loop nest and drives operand addresses, operand-valid, accumulator init and clear, and C write-back.
- Reports completion and zero-size errors. Sits between the host/config path and the MAC-array datapath.

Parameters:
- SizeAddrWidth, 8, width of block-count inputs and loop counters.
- AddrWidth, 16, width of SRAM addresses and base addresses.
- MacLatency, 1, cycles from operand issue to that product being in the accumulator (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- cfg_valid_i  in  1  job descriptor valid
- cfg_ready_o  out  1  scheduler can accept a job
- M_size_i  in  SizeAddrWidth  M block count
- K_size_i  in  SizeAddrWidth  K block count
- N_size_i  in  SizeAddrWidth  N block count
- a_base_i  in  AddrWidth  SRAM A base address
- b_base_i  in  AddrWidth  SRAM B base address
- c_base_i  in  AddrWidth  SRAM C base address
- stall_i  in  1  operands not available this cycle; hold the loop
- sram_a_addr_o  out  AddrWidth  A block address
- sram_b_addr_o  out  AddrWidth  B block address
- sram_c_addr_o  out  AddrWidth  C block address
- operand_valid_o  out  1  A/B operands issued to the MAC array this cycle
- init_save_o  out  1  issue is first K block: accumulator overwrites, no accumulate
- acc_clr_o  out  1  clear MAC accumulators
- sram_c_we_o  out  1  C write enable
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse: accepted job had a zero size

Behaviour:
- One clock; reset is synchronous and active-low: clk_i, rst_ni.
- Reset value of every output is 0, except acc_clr_o=1 and cfg_ready_o=1. State is IDLE; counters, tag pipe and latched config are 0.
- A reset asserted mid-job aborts the job immediately. No write or done pulse follows it.
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cfg_ready_o=1, acc_clr_o=1.
  - On cfg_valid_i, sizes and bases are latched and the counters m, n, k are zeroed.
  - If any size is 0, the job goes to DONE and err_o pulses in the DONE cycle. No SRAM activity occurs.
  - Otherwise the job goes to RUN.
- RUN:
  - busy_o=1.
  - On a cycle with !stall_i, the scheduler issues (m,n,k) with operand_valid_o=1 and init_save_o=(k==0).
  - The loop advances k, then n, then m. All counters wrap at their size.
  - On a cycle with stall_i, counters and addresses hold, and operand_valid_o=0 and init_save_o=0.
  - The issue of (M-1,N-1,K-1) moves the block to DRAIN.
- Addresses are combinational from the registered counters and latched config. All arithmetic is done in AddrWidth bits, truncated modulo 2^AddrWidth.
  - sram_a_addr_o = a_base + m*K + k
  - sram_b_addr_o = b_base + n*K + k
  - In IDLE and DONE both addresses are 0.
- Write-back tag pipe:
  - Each issue pushes a tag {valid, last=(k==K-1), m, n} into a MacLatency-deep shift register. The register shifts every cycle, including stall cycles; a stall inserts valid=0.
  - When the pipe output has valid&&last: sram_c_we_o=1 and sram_c_addr_o = c_base + m*N + n, using that tag's m and n.
  - Otherwise sram_c_addr_o=0.
- DRAIN:
  - busy_o=1. stall_i is ignored.
  - The block stays in DRAIN exactly MacLatency cycles; the final C write occurs in the last DRAIN cycle. It then moves to DONE.
- DONE:
  - done_o=1 for one cycle, and busy_o=0. The next state is IDLE.
  - cfg_ready_o=0 in DONE, so a new job is accepted no earlier than the following cycle.
- cfg_valid_i is ignored outside IDLE.
- Simultaneous stall_i and a last-K issue: the stall wins and no issue happens that cycle.

Decomposition:
- gemm_sched_pkg holds:
  - the state enum sched_state_e (IDLE, RUN, DRAIN, DONE);
  - the packed struct wb_tag_t {valid, last, m, n} parameterised via SizeAddrWidth;
  - the job descriptor struct gemm_job_t.
- One sub-module, gemm_wb_tag_pipe: the MacLatency-deep tag shift register with valid/last decode.

Test Plan:
- M=2,K=3,N=2, bases 0/0x100/0x200, MacLatency=1, no stall, accept at cycle 0:
  - operand_valid_o is high on cycles 1–12;
  - init_save_o is high on cycles 1, 4, 7, 10;
  - C writes occur on cycles 4, 7, 10, 13 at addresses 0x200, 0x201, 0x202, 0x203;
  - done_o pulses on cycle 14.
- Same job with stall_i high on cycles 3–4:
  - issues occur on cycles 1, 2, 5–14;
  - the first write is on cycle 6 at 0x200, the last write on cycle 15;
  - done_o pulses on cycle 16;
  - sram_a_addr_o holds 0x002 through the stall.
- Job with K_size=0:
  - cfg is accepted;
  - err_o and done_o pulse together in cycle 1;
  - operand_valid_o and sram_c_we_o never assert.
- Run with MacLatency=3, M=K=N=1:
  - a single issue on cycle 1 with init_save_o=1;
  - the write is on cycle 4 at c_base;
  - done_o pulses on cycle 5.
- rst_ni low for one cycle mid-RUN:
  - on the next cycle all outputs are at reset values and cfg_ready_o=1;
  - no further write occurs;
  - a new job then runs correctly.
- Address wrap: a_base=0xFFFF, M=1,K=2,N=1:
  - sram_a_addr_o is 0xFFFF, then 0x0000.
